branch_history_predictor: RTL

// - Dynamic branch predictor feeding the branch flush/PC-select logic.
// - Holds a table of 2-bit saturating counters indexed by PC.
// - ID stage: table read combinationally gives the taken/not-taken prediction.
// - EX stage: the table is trained with the resolved branch outcome.

---
 rtl/branch_history_predictor.sv | 84 ++++++++
 1 files changed

// File: rtl/branch_history_predictor.sv
// PC-indexed table of 2-bit saturating counters: combinational predict in ID, train from EX.
// Define PREDICTOR_STATS_EN to add saturating branch / mispredict counters.
module branch_history_predictor #(
    parameter int unsigned IDX_W      = 4,
    parameter logic [1:0]  INIT_STATE = 2'b01,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      ID_pc_i,
    output logic             Predict_o,
    input  logic             EX_Branch_i,
    input  logic             EX_Zero_i,
    input  logic             EX_Predict_i,
    input  logic [31:0]      EX_pc_i,
    input  logic             Stall_i,
    output logic             Mispredict_o
`ifdef PREDICTOR_STATS_EN
    ,
    output logic [CNT_W-1:0] Branch_cnt_o,
    output logic [CNT_W-1:0] Mispred_cnt_o
`endif
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;

    logic [IDX_W-1:0]        w_rd_idx;
    logic [IDX_W-1:0]        w_wr_idx;
    logic                    w_upd;
    logic [ENTRIES-1:0][1:0] w_table;
    logic                    w_unused;

    assign w_rd_idx     = ID_pc_i[IDX_W+1:2];
    assign w_wr_idx     = EX_pc_i[IDX_W+1:2];
    // A stalled branch sits in EX repeatedly; train only on the cycle it moves on.
    assign w_upd        = EX_Branch_i & ~Stall_i;
    assign Predict_o    = w_table[w_rd_idx][1];
    assign Mispredict_o = EX_Branch_i & (EX_Predict_i ^ EX_Zero_i);
    assign w_unused     = ^{ID_pc_i[31:IDX_W+2], ID_pc_i[1:0], EX_pc_i[31:IDX_W+2], EX_pc_i[1:0]};

    generate
        for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
            logic       w_hit;
            logic [1:0] r_cnt;

            assign w_hit      = w_upd && (w_wr_idx == IDX_W'(g));
            assign w_table[g] = r_cnt;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_cnt <= INIT_STATE;
                end else if (w_hit) begin
                    if (EX_Zero_i) begin
                        if (r_cnt != 2'b11) r_cnt <= r_cnt + 2'b01;
                    end else begin
                        if (r_cnt != 2'b00) r_cnt <= r_cnt - 2'b01;
                    end
                end
            end
        end
    endgenerate

`ifdef PREDICTOR_STATS_EN
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_upd) begin
            if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
            if (Mispredict_o && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end

    assign Branch_cnt_o  = r_branch_cnt;
    assign Mispred_cnt_o = r_mispred_cnt;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule
